// File: rtl/wb_mem_pkg.sv
// Shared helpers for the banked Wishbone memory: bank/row geometry,
// bank decode and byte-lane merge.
package wb_mem_pkg;

    // Widest data bus supported by byte_merge; callers cast to and from this width.
    localparam int MAX_DATA_W = 512;
    localparam int MAX_SEL_W  = MAX_DATA_W / 8;

    function automatic int bank_bits_f(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 0;
    endfunction

    function automatic int row_w_f(input int addr_w, input int num_banks);
        return addr_w - bank_bits_f(num_banks);
    endfunction

    function automatic logic [31:0] bank_of(input logic [31:0] addr, input int addr_w,
                                            input int bank_bits);
        if (bank_bits == 0) begin
            return '0;
        end
        return (addr >> (addr_w - bank_bits)) & ((32'd1 << bank_bits) - 32'd1);
    endfunction

    function automatic logic [MAX_DATA_W-1:0] byte_merge(input logic [MAX_DATA_W-1:0] old_word,
                                                         input logic [MAX_DATA_W-1:0] new_word,
                                                         input logic [MAX_SEL_W-1:0] sel);
        logic [MAX_DATA_W-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_SEL_W; i++) begin
            if (sel[i]) begin
                merged[i*8 +: 8] = new_word[i*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_banked_mem_if.sv
// Flattened multi-port Wishbone B4 pipelined bus; port p occupies slice p of each vector.
interface wb_banked_mem_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
);
    localparam int SEL_W = DATA_W / 8;

    logic [NUM_PORTS-1:0]        wb_cyc_i;
    logic [NUM_PORTS-1:0]        wb_stb_i;
    logic [NUM_PORTS-1:0]        wb_we_i;
    logic [NUM_PORTS*ADDR_W-1:0] wb_adr_i;
    logic [NUM_PORTS*DATA_W-1:0] wb_dat_i;
    logic [NUM_PORTS*SEL_W-1:0]  wb_sel_i;
    logic [NUM_PORTS-1:0]        wb_stall_o;
    logic [NUM_PORTS-1:0]        wb_ack_o;
    logic [NUM_PORTS*DATA_W-1:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_stall_o, wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_stall_o, wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/wb_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last winner,
// and the pointer only moves when something is granted.
module wb_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         enable,
    output logic [N-1:0] grant
);
    localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

    logic [PTR_W-1:0] ptr_reg;
    logic [PTR_W-1:0] ptr_next;
    logic [N-1:0]     grant_next;
    logic             found;
    int               idx;

    always_comb begin
        grant_next = '0;
        ptr_next   = ptr_reg;
        found      = 1'b0;
        idx        = 0;
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_reg) + k) % N;
            if (!found && enable && req[idx]) begin
                grant_next[idx] = 1'b1;
                ptr_next        = PTR_W'(idx);
                found           = 1'b1;
            end
        end
    end

    assign grant = grant_next;

    // Reset to the last port so port 0 is first in line.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr_reg <= PTR_W'(N - 1);
        end else begin
            ptr_reg <= ptr_next;
        end
    end
endmodule

// File: rtl/wb_banked_mem.sv
// Multi-port, multi-bank Wishbone B4 pipelined memory: top address bits pick the
// bank, each bank has its own round-robin arbiter, losers see STALL.
module wb_banked_mem
    import wb_mem_pkg::*;
#(
    parameter int NUM_PORTS = 2,
    parameter int NUM_BANKS = 2,
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32
) (
    input logic           clk,
    input logic           rst,
    wb_banked_mem_if.slave bus
);
    localparam int SEL_W     = DATA_W / 8;
    localparam int BANK_BITS = bank_bits_f(NUM_BANKS);
    localparam int ROW_W     = row_w_f(ADDR_W, NUM_BANKS);
    localparam int DEPTH     = 2 ** ROW_W;
    localparam int BSEL_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

    logic [NUM_PORTS-1:0] req_any;
    logic [NUM_PORTS-1:0] port_grant;
    logic [BSEL_W-1:0]    port_bank  [NUM_PORTS];
    logic [ROW_W-1:0]     port_row   [NUM_PORTS];
    logic [NUM_PORTS-1:0] bank_grant [NUM_BANKS];
    logic [DATA_W-1:0]    bank_rd    [NUM_BANKS];

    genvar gi;

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_decode
        assign req_any[gi]   = bus.wb_cyc_i[gi] & bus.wb_stb_i[gi];
        assign port_bank[gi] = BSEL_W'(bank_of(32'(bus.wb_adr_i[gi*ADDR_W +: ADDR_W]),
                                               ADDR_W, BANK_BITS));
        assign port_row[gi]  = bus.wb_adr_i[gi*ADDR_W +: ROW_W];
    end

    always_comb begin
        port_grant = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            port_grant = port_grant | bank_grant[b];
        end
    end

    assign bus.wb_stall_o = req_any & ~port_grant;

    for (gi = 0; gi < NUM_BANKS; gi++) begin : g_bank
        logic [DATA_W-1:0]    mem [DEPTH];
        logic [DATA_W-1:0]    rd_reg;
        logic [NUM_PORTS-1:0] req_vec;
        logic [ROW_W-1:0]     row_sel;
        logic [DATA_W-1:0]    wdata_sel;
        logic [SEL_W-1:0]     be_sel;
        logic                 we_sel;
        logic                 go;

        always_comb begin
            req_vec = '0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                req_vec[p] = req_any[p] && (port_bank[p] == BSEL_W'(gi));
            end
        end

        wb_rr_arbiter #(.N(NUM_PORTS)) u_arb (
            .clk    (clk),
            .rst    (rst),
            .req    (req_vec),
            .enable (1'b1),
            .grant  (bank_grant[gi])
        );

        // Grant is one-hot, so OR-style selection of the winner's request fields.
        always_comb begin
            row_sel   = '0;
            wdata_sel = '0;
            be_sel    = '0;
            we_sel    = 1'b0;
            for (int p = 0; p < NUM_PORTS; p++) begin
                if (bank_grant[gi][p]) begin
                    row_sel   = port_row[p];
                    wdata_sel = bus.wb_dat_i[p*DATA_W +: DATA_W];
                    be_sel    = bus.wb_sel_i[p*SEL_W +: SEL_W];
                    we_sel    = bus.wb_we_i[p];
                end
            end
        end

        // Nothing is committed on a reset edge; the request is dropped.
        assign go = (|bank_grant[gi]) & rst;

        always_ff @(posedge clk) begin
            if (go && we_sel) begin
                mem[row_sel] <= DATA_W'(byte_merge(MAX_DATA_W'(mem[row_sel]),
                                                   MAX_DATA_W'(wdata_sel),
                                                   MAX_SEL_W'(be_sel)));
            end
            if (go && !we_sel) begin
                rd_reg <= mem[row_sel];
            end
        end

        assign bank_rd[gi] = rd_reg;
    end

    for (gi = 0; gi < NUM_PORTS; gi++) begin : g_port
        logic              ack_pend_reg;
        logic              rd_pend_reg;
        logic [BSEL_W-1:0] bank_pend_reg;
        logic [DATA_W-1:0] dat_hold_reg;
        logic [DATA_W-1:0] dat_next;

        // Read data comes straight from the bank register in the ack cycle,
        // otherwise the port keeps showing its last read word.
        assign dat_next = (rd_pend_reg && bus.wb_cyc_i[gi]) ? bank_rd[bank_pend_reg]
                                                            : dat_hold_reg;

        always_ff @(posedge clk) begin
            if (!rst) begin
                ack_pend_reg  <= 1'b0;
                rd_pend_reg   <= 1'b0;
                bank_pend_reg <= '0;
                dat_hold_reg  <= '0;
            end else begin
                ack_pend_reg  <= port_grant[gi];
                rd_pend_reg   <= port_grant[gi] & ~bus.wb_we_i[gi];
                bank_pend_reg <= port_bank[gi];
                dat_hold_reg  <= dat_next;
            end
        end

        assign bus.wb_ack_o[gi]                 = ack_pend_reg & bus.wb_cyc_i[gi];
        assign bus.wb_dat_o[gi*DATA_W +: DATA_W] = dat_next;
    end
endmodule

// File: tb/tb_wb_banked_mem.sv
// Directed scoreboard bench for wb_banked_mem: stimulus pushes expected acks,
// a negedge monitor pops and compares them against ack timing and read data.
module tb_wb_banked_mem;
    localparam int NP = 2;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc_n = 0;
    int   n_vec = 0;
    int   n_err = 0;

    exp_t        exp_q [NP][$];
    logic [NP-1:0] no_ack;
    logic [NP-1:0] pend_rd;
    logic [31:0]   pend_exp [NP];
    logic [31:0]   last_rd  [NP];

    wb_banked_mem_if #(.NUM_PORTS(NP), .ADDR_W(8), .DATA_W(32)) bus ();

    wb_banked_mem #(.NUM_PORTS(NP), .NUM_BANKS(2), .ADDR_W(8), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    // Monitor: every ack must match the head of that port's queue in cycle and data.
    always @(negedge clk) begin
        for (int p = 0; p < NP; p++) begin
            if (bus.wb_ack_o[p]) begin
                n_vec++;
                if (exp_q[p].size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_ack port%0d cycle %0d: ack=1 required 0", p, cyc_n);
                end else begin
                    exp_t e;
                    e = exp_q[p].pop_front();
                    if (e.cyc != cyc_n || bus.wb_dat_o[p*32 +: 32] !== e.data) begin
                        n_err++;
                        $display("FAIL %s port%0d: got cycle %0d dat %h, required cycle %0d dat %h",
                                 e.name, p, cyc_n, bus.wb_dat_o[p*32 +: 32], e.cyc, e.data);
                    end
                end
            end else if (exp_q[p].size() > 0 && exp_q[p][0].cyc <= cyc_n) begin
                exp_t e;
                e = exp_q[p].pop_front();
                n_vec++;
                n_err++;
                $display("FAIL %s port%0d: no ack in cycle %0d, required ack dat %h",
                         e.name, p, e.cyc, e.data);
            end
        end
    end

    task automatic set_req(input int p, input logic we, input logic [7:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel, input logic [31:0] exp_rd);
        bus.wb_cyc_i[p]        = 1'b1;
        bus.wb_stb_i[p]        = 1'b1;
        bus.wb_we_i[p]         = we;
        bus.wb_adr_i[p*8 +: 8] = adr;
        bus.wb_dat_i[p*32 +: 32] = dat;
        bus.wb_sel_i[p*4 +: 4] = sel;
        pend_rd[p]             = ~we;
        pend_exp[p]            = exp_rd;
    endtask

    // Check stall mid-cycle, queue expected acks for accepted ports, then clock.
    task automatic step(input logic [NP-1:0] exp_stall, input string name);
        logic [NP-1:0] req;
        exp_t e;
        @(negedge clk);
        req = bus.wb_cyc_i & bus.wb_stb_i;
        n_vec++;
        if (bus.wb_stall_o !== exp_stall) begin
            n_err++;
            $display("FAIL %s stall: got %b required %b", name, bus.wb_stall_o, exp_stall);
        end
        for (int p = 0; p < NP; p++) begin
            if (req[p] && !exp_stall[p] && !no_ack[p]) begin
                e.cyc  = cyc_n + 1;
                e.data = pend_rd[p] ? pend_exp[p] : last_rd[p];
                e.name = name;
                exp_q[p].push_back(e);
                if (pend_rd[p]) last_rd[p] = pend_exp[p];
            end
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < NP; p++) begin
            if (req[p] && !exp_stall[p]) bus.wb_stb_i[p] = 1'b0;
        end
    endtask

    task automatic check_zero(input string name);
        @(negedge clk);
        n_vec += 3;
        if (bus.wb_ack_o !== '0) begin
            n_err++;
            $display("FAIL %s ack: got %b required 00", name, bus.wb_ack_o);
        end
        if (bus.wb_dat_o !== '0) begin
            n_err++;
            $display("FAIL %s dat_o: got %h required 0", name, bus.wb_dat_o);
        end
        if (bus.wb_stall_o !== '0) begin
            n_err++;
            $display("FAIL %s stall: got %b required 00", name, bus.wb_stall_o);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        bus.wb_cyc_i = '0; bus.wb_stb_i = '0; bus.wb_we_i = '0;
        bus.wb_adr_i = '0; bus.wb_dat_i = '0; bus.wb_sel_i = '0;
        no_ack = '0; pend_rd = '0;
        for (int p = 0; p < NP; p++) begin
            pend_exp[p] = '0;
            last_rd[p]  = '0;
        end
        idle(2);
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        bus.wb_cyc_i = '1;

        // Different banks in the same cycle, then cross-read.
        set_req(0, 1'b1, 8'hF1, 32'hABABABAB, 4'hF, 32'h0);
        set_req(1, 1'b1, 8'h05, 32'hF0F0F0F0, 4'hF, 32'h0);
        step(2'b00, "dual_wr");
        set_req(0, 1'b0, 8'h05, 32'h0, 4'hF, 32'hF0F0F0F0);
        set_req(1, 1'b0, 8'hF1, 32'h0, 4'hF, 32'hABABABAB);
        step(2'b00, "dual_rd");

        // Byte-lane merge.
        set_req(0, 1'b1, 8'h35, 32'h77777777, 4'hF, 32'h0);
        step(2'b00, "wr_full");
        set_req(0, 1'b1, 8'h35, 32'h00AA0000, 4'b0100, 32'h0);
        step(2'b00, "wr_byte2");
        set_req(0, 1'b0, 8'h35, 32'h0, 4'hF, 32'h77AA7777);
        step(2'b00, "rd_merged");

        // Preload then back-to-back pipelined reads.
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b1, 8'(8'h10 + i), 32'(i + 1), 4'hF, 32'h0);
            step(2'b00, "preload");
        end
        for (int i = 0; i < 3; i++) begin
            set_req(0, 1'b0, 8'(8'h10 + i), 32'h0, 4'hF, 32'(i + 1));
            step(2'b00, "pipe_rd");
        end

        // Read-after-write on consecutive cycles.
        set_req(0, 1'b1, 8'h20, 32'h5, 4'hF, 32'h0);
        step(2'b00, "raw_wr");
        set_req(0, 1'b0, 8'h20, 32'h0, 4'hF, 32'h5);
        step(2'b00, "raw_rd");

        set_req(1, 1'b1, 8'h90, 32'hCAFEF00D, 4'hF, 32'h0);
        step(2'b00, "preload_90");
        idle(2);

        // Fresh arbitration pointers: port 0 first, then port 1 on the next conflict.
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        check_zero("reset2");
        @(posedge clk); #1;
        set_req(0, 1'b1, 8'hF4, 32'h12345678, 4'hF, 32'h0);
        set_req(1, 1'b0, 8'h90, 32'h0, 4'hF, 32'hCAFEF00D);
        step(2'b10, "conflict_A_first");
        set_req(0, 1'b0, 8'hF4, 32'h0, 4'hF, 32'h12345678);
        step(2'b01, "conflict_B_first");
        step(2'b00, "conflict_A_after");

        // Abort: cyc dropped in the ack cycle suppresses the ack.
        set_req(0, 1'b0, 8'h10, 32'h0, 4'hF, 32'h1);
        no_ack = 2'b01;
        step(2'b00, "abort_rd");
        bus.wb_cyc_i[0] = 1'b0;
        no_ack = 2'b00;
        @(negedge clk);
        n_vec++;
        if (bus.wb_ack_o[0] !== 1'b0) begin
            n_err++;
            $display("FAIL abort_ack: got ack=%b required 0", bus.wb_ack_o[0]);
        end
        @(posedge clk); #1;
        bus.wb_cyc_i[0] = 1'b1;

        set_req(1, 1'b0, 8'h11, 32'h0, 4'hF, 32'h2);
        step(2'b00, "b_rd_alone");

        // Reset while port 1 is stalled drops both requests.
        set_req(0, 1'b0, 8'h12, 32'h0, 4'hF, 32'h3);
        set_req(1, 1'b0, 8'h11, 32'h0, 4'hF, 32'h2);
        no_ack = 2'b11;
        rst = 1'b0;
        step(2'b10, "rst_stall");
        rst = 1'b1;
        bus.wb_stb_i = '0;
        no_ack = 2'b00;
        for (int p = 0; p < NP; p++) last_rd[p] = '0;
        check_zero("rst_drop");
        @(posedge clk); #1;
        set_req(0, 1'b0, 8'h12, 32'h0, 4'hF, 32'h3);
        set_req(1, 1'b0, 8'h11, 32'h0, 4'hF, 32'h2);
        step(2'b10, "post_rst_A_first");
        step(2'b00, "post_rst_B");

        idle(3);
        for (int p = 0; p < NP; p++) begin
            n_vec++;
            if (exp_q[p].size() != 0) begin
                n_err++;
                $display("FAIL drain port%0d: %0d acks outstanding, required 0", p, exp_q[p].size());
            end
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/wb_banked_mem.md
Name: wb_banked_mem

Overview:
Multi-port, multi-bank Wishbone B4 pipelined slave memory. It is the parametrised successor of the fixed two-port/two-RAM memory_top. NUM_PORTS masters share NUM_BANKS single-port RAM banks. The top address bits select the bank. A per-bank round-robin arbiter resolves conflicts, and losing ports see STALL.

Parameters:
NUM_PORTS, 2, number of Wishbone slave ports (>=1)
NUM_BANKS, 2, number of RAM banks (power of 2, >=1)
ADDR_W, 8, word address width per port
DATA_W, 32, data width (multiple of 8)
SEL_W, DATA_W/8, byte-select width (derived, do not override)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; one clock; reset is synchronous and active-low (rst=0 resets)
wb_cyc_i  in  NUM_PORTS  bus cycle active, one bit per port
wb_stb_i  in  NUM_PORTS  request strobe
wb_we_i  in  NUM_PORTS  1=write, 0=read
wb_adr_i  in  NUM_PORTS*ADDR_W  word address, port p at [p*ADDR_W +: ADDR_W]
wb_dat_i  in  NUM_PORTS*DATA_W  write data
wb_sel_i  in  NUM_PORTS*SEL_W  byte enables
wb_stall_o  out  NUM_PORTS  request not accepted this cycle
wb_ack_o  out  NUM_PORTS  transfer complete; read data valid
wb_dat_o  out  NUM_PORTS*DATA_W  read data

Behaviour:
- Bank decode: bank = adr[ADDR_W-1 -: BANK_BITS], row = remaining low bits. BANK_BITS = clog2(NUM_BANKS); when NUM_BANKS=1, all addresses go to bank 0. Bank depth = 2**(ADDR_W-BANK_BITS).
- Port p requests bank b when cyc[p] & stb[p] and the decoded bank equals b.
- Arbitration (combinational, per bank):
  - Round-robin starting at rr_ptr[b]+1 mod NUM_PORTS; exactly one grant per bank per cycle.
  - rr_ptr[b] is updated to the granted port only on a grant.
- stall[p] = cyc[p] & stb[p] & ~grant[p]. It is combinational and 0 when the port is not requesting.
- Acceptance: stb & ~stall at a rising edge.
  - Write: bytes with sel=1 are written at that edge; other bytes are unchanged.
  - Read: the row is read at that edge.
- Latency:
  - ack[p] asserts exactly 1 cycle after acceptance, for one cycle per accepted request.
  - For reads, dat_o[p] is valid in the ack cycle.
  - For writes, dat_o[p] holds its previous value.
- Pipelining: a port may be accepted on consecutive cycles. Acks return in order, one per cycle.
- Read-after-write: a read of the same row accepted the cycle after a write returns the new data.
- Simultaneous events:
  - Two ports on different banks are both accepted in the same cycle.
  - Same-bank ports are serialised by the arbiter; there is no same-bank same-cycle write/read hazard.
- Abort: if cyc[p]=0 in the cycle where ack[p] would assert, ack is suppressed. A write already accepted stays committed.
- Reset (rst=0 at an edge):
  - ack_o=0, dat_o=0, all rr_ptr=NUM_PORTS-1 (so port 0 has first priority).
  - Pending acks are discarded; stall follows the inputs combinationally.
  - RAM contents are not reset; a read before any write returns undefined data.
  - Reset during a stall drops the stalled request; the master must reissue it.
- No error/retry signalling; every in-range address is valid.

Decomposition:
- Package wb_mem_pkg holds:
  - localparam helpers: BANK_BITS, ROW_W.
  - Function bank_of(addr) and function byte_merge(old, new, sel).
- One sub-module, wb_rr_arbiter:
  - Parameter N; inputs req[N] and enable; outputs grant[N] one-hot.
  - Holds its internal pointer and uses the same synchronous active-low rst.
  - Instantiated NUM_BANKS times via generate.
- Banks are behavioural register arrays inside the top, in a generate loop.

Test Plan:
- Defaults; reset; same cycle, A writes 0xF1=ABABABAB and B writes 0x05=F0F0F0F0 (banks 1 and 0, sel=F) -> stall A/B=0, ack A/B=1 next cycle. Then read A@0x05 and B@0xF1 -> dat_o A=F0F0F0F0, B=ABABABAB.
- First conflict after reset: A writes 0xF4=12345678 and B reads 0x90, same cycle -> A accepted with stall B=1; B accepted the following cycle; ack A at t+1, ack B at t+2. Next conflict -> B granted first.
- Write 0x35=77777777, then write 0x35=00AA0000 with sel=0100 -> read 0x35 returns 77AA7777.
- Port A pipelined reads of 0x10, 0x11, 0x12 (preloaded 1,2,3) on consecutive cycles with no conflict -> ack=1 on three consecutive cycles, dat_o=1,2,3 in order.
- Write 0x20=5 accepted, read 0x20 the next cycle -> read ack data=5.
- Read accepted, cyc A dropped next cycle -> no ack. With B stalled, rst=0 for one edge -> ack_o=0, dat_o=0; B is re-stalled only if still requesting, and port 0 wins the next conflict.
